instr_executor: RTL and testbench

- Read-side consumer of the instruction queue.
- Pops 4-bit saved instructions (torque[3:2], direction[1:0]) from the FIFO one at a time.
- Holds each instruction for a fixed step time, then coasts for a gap time.
- While holding, it drives left/right motor PWM and direction.
- Sits between the FIFO read port and the motor driver / LEDR / seven-seg display logic.

---
 rtl/instr_executor.sv | 211 +++++++++++++++++++++
 tb/tb_instr_executor.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/instr_executor.sv
`timescale 1ns/1ps
// Instruction-queue consumer: pops 4-bit {torque, direction} entries and drives the motors for a fixed step.
// Optional build macro INSTR_EXECUTOR_STEP_COUNT_EN adds the saturating steps_executed counter output.
module instr_executor #(
    parameter int STEP_CYCLES = 50_000_000,
    parameter int GAP_CYCLES  = 5_000_000
) (
    input  logic       CLOCK50,
    input  logic       reset_n,
    input  logic       start,
    input  logic       abort,
    input  logic       fifo_empty,
    output logic       fifo_rd_en,
    input  logic [3:0] fifo_data,
    output logic       busy,
    output logic [3:0] cur_instr,
    output logic       left_pwm,
    output logic       right_pwm,
    output logic       left_fwd,
    output logic       right_fwd,
    output logic       step_done,
    output logic       queue_done
`ifdef INSTR_EXECUTOR_STEP_COUNT_EN
    ,
    output logic [7:0] steps_executed
`endif
);

    localparam int MAX_CYCLES = (STEP_CYCLES > GAP_CYCLES) ? STEP_CYCLES : GAP_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_RUN   = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    state_t           state_r, state_s;
    logic [CNT_W-1:0] step_cnt_r, step_cnt_s;
    logic [7:0]       pwm_cnt_r, pwm_cnt_s;
    logic [3:0]       instr_q_r, instr_q_s;

    logic       rd_en_s, busy_s, left_pwm_s, right_pwm_s, left_fwd_s, right_fwd_s;
    logic       step_done_s, queue_done_s;
    logic [3:0] cur_instr_s;

    // Duty threshold: torque 0..3 maps to 64/128/192/256 counts out of 256.
    function automatic logic [8:0] duty_of(input logic [1:0] torque);
        return {1'b0, torque, 6'b000000} + 9'd64;
    endfunction

    // Direction decode into {left_fwd, right_fwd}.
    function automatic logic [1:0] fwd_of(input logic [1:0] dir);
        logic [1:0] fwd;
        case (dir)
            2'b00:   fwd = 2'b11;
            2'b01:   fwd = 2'b00;
            2'b10:   fwd = 2'b01;
            2'b11:   fwd = 2'b10;
            default: fwd = 2'b00;
        endcase
        return fwd;
    endfunction

    // State, step counter, PWM counter and latched instruction.
    always_ff @(posedge CLOCK50 or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            step_cnt_r <= CNT_ZERO;
            pwm_cnt_r  <= 8'd0;
            instr_q_r  <= 4'd0;
        end else begin
            state_r    <= state_s;
            step_cnt_r <= step_cnt_s;
            pwm_cnt_r  <= pwm_cnt_s;
            instr_q_r  <= instr_q_s;
        end
    end

    // Next-state and counter update; abort overrides every state.
    always_comb begin
        state_s    = state_r;
        step_cnt_s = step_cnt_r;
        pwm_cnt_s  = pwm_cnt_r;
        instr_q_s  = instr_q_r;
        if (abort) begin
            state_s    = ST_IDLE;
            step_cnt_s = CNT_ZERO;
            pwm_cnt_s  = 8'd0;
            instr_q_s  = 4'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start && !fifo_empty) begin
                        state_s = ST_FETCH;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_FETCH: state_s = ST_LOAD;
                ST_LOAD: begin
                    instr_q_s  = fifo_data;
                    step_cnt_s = CNT_ZERO;
                    pwm_cnt_s  = 8'd0;
                    state_s    = ST_RUN;
                end
                ST_RUN: begin
                    pwm_cnt_s = pwm_cnt_r + 8'd1;
                    if (step_cnt_r == STEP_LAST) begin
                        step_cnt_s = CNT_ZERO;
                        if (GAP_CYCLES > 0) begin
                            state_s = ST_GAP;
                        end else if (!fifo_empty) begin
                            state_s = ST_FETCH;
                        end else begin
                            state_s = ST_IDLE;
                        end
                    end else begin
                        step_cnt_s = step_cnt_r + CNT_ONE;
                    end
                end
                ST_GAP: begin
                    if (step_cnt_r == GAP_LAST) begin
                        step_cnt_s = CNT_ZERO;
                        state_s    = fifo_empty ? ST_IDLE : ST_FETCH;
                    end else begin
                        step_cnt_s = step_cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_s    = ST_IDLE;
                    step_cnt_s = CNT_ZERO;
                    pwm_cnt_s  = 8'd0;
                end
            endcase
        end
    end

    // Output values for the coming cycle, derived from the next state so the registered outputs line up with it.
    always_comb begin
        rd_en_s = (state_s == ST_FETCH);
        busy_s  = (state_s != ST_IDLE);
        if (state_s == ST_RUN) begin
            cur_instr_s               = instr_q_s;
            {left_fwd_s, right_fwd_s} = fwd_of(instr_q_s[1:0]);
            left_pwm_s                = ({1'b0, pwm_cnt_s} < duty_of(instr_q_s[3:2]));
            right_pwm_s               = left_pwm_s;
            step_done_s               = (step_cnt_s == STEP_LAST);
        end else begin
            cur_instr_s = 4'd0;
            left_fwd_s  = 1'b0;
            right_fwd_s = 1'b0;
            left_pwm_s  = 1'b0;
            right_pwm_s = 1'b0;
            step_done_s = 1'b0;
        end
        queue_done_s = (state_s == ST_IDLE) && !abort &&
                       ((state_r == ST_RUN) || (state_r == ST_GAP));
    end

    // Registered outputs.
    always_ff @(posedge CLOCK50 or negedge reset_n) begin
        if (!reset_n) begin
            fifo_rd_en <= 1'b0;
            busy       <= 1'b0;
            cur_instr  <= 4'd0;
            left_pwm   <= 1'b0;
            right_pwm  <= 1'b0;
            left_fwd   <= 1'b0;
            right_fwd  <= 1'b0;
            step_done  <= 1'b0;
            queue_done <= 1'b0;
        end else begin
            fifo_rd_en <= rd_en_s;
            busy       <= busy_s;
            cur_instr  <= cur_instr_s;
            left_pwm   <= left_pwm_s;
            right_pwm  <= right_pwm_s;
            left_fwd   <= left_fwd_s;
            right_fwd  <= right_fwd_s;
            step_done  <= step_done_s;
            queue_done <= queue_done_s;
        end
    end

`ifdef INSTR_EXECUTOR_STEP_COUNT_EN
    logic [7:0] steps_r;

    // Saturating step tally; restarts on an accepted start, survives abort.
    always_ff @(posedge CLOCK50 or negedge reset_n) begin
        if (!reset_n) begin
            steps_r <= 8'd0;
        end else if ((state_r == ST_IDLE) && start && !fifo_empty && !abort) begin
            steps_r <= 8'd0;
        end else if (step_done_s && (steps_r != 8'd255)) begin
            steps_r <= steps_r + 8'd1;
        end else begin
            steps_r <= steps_r;
        end
    end

    assign steps_executed = steps_r;
`endif

endmodule

// File: tb/tb_instr_executor.sv
`timescale 1ns/1ps
// Self-checking bench for instr_executor: a phase-timeline reference model predicts every output cycle by cycle.
module tb_instr_executor;

    localparam int STEP_A = 8;
    localparam int GAP_A  = 2;
    localparam int STEP_B = 512;
    localparam int GAP_B  = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n = 1'b0;
    logic       start_a = 1'b0;
    logic       start_b = 1'b0;
    logic       abort   = 1'b0;
    logic       fifo_empty;
    logic [3:0] fifo_data = 4'd0;

    logic       rd_en_a, busy_a, lpwm_a, rpwm_a, lfwd_a, rfwd_a, sd_a, qd_a;
    logic [3:0] cur_a;
    logic       rd_en_b, busy_b, lpwm_b, rpwm_b, lfwd_b, rfwd_b, sd_b, qd_b;
    logic [3:0] cur_b;

    instr_executor #(.STEP_CYCLES(STEP_A), .GAP_CYCLES(GAP_A)) dut_a (
        .CLOCK50(clk), .reset_n(reset_n), .start(start_a), .abort(abort),
        .fifo_empty(fifo_empty), .fifo_rd_en(rd_en_a), .fifo_data(fifo_data),
        .busy(busy_a), .cur_instr(cur_a), .left_pwm(lpwm_a), .right_pwm(rpwm_a),
        .left_fwd(lfwd_a), .right_fwd(rfwd_a), .step_done(sd_a), .queue_done(qd_a)
    );

    instr_executor #(.STEP_CYCLES(STEP_B), .GAP_CYCLES(GAP_B)) dut_b (
        .CLOCK50(clk), .reset_n(reset_n), .start(start_b), .abort(abort),
        .fifo_empty(fifo_empty), .fifo_rd_en(rd_en_b), .fifo_data(fifo_data),
        .busy(busy_b), .cur_instr(cur_b), .left_pwm(lpwm_b), .right_pwm(rpwm_b),
        .left_fwd(lfwd_b), .right_fwd(rfwd_b), .step_done(sd_b), .queue_done(qd_b)
    );

    // Shared FIFO model: data appears the cycle after a pop strobe.
    logic [3:0] mem [0:31];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if ((rd_en_a || rd_en_b) && (rd_ptr != wr_ptr)) begin
            fifo_data <= mem[rd_ptr[4:0]];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    logic [11:0] obs_a, obs_b;
    assign obs_a = {busy_a, rd_en_a, cur_a, lpwm_a, rpwm_a, lfwd_a, rfwd_a, sd_a, qd_a};
    assign obs_b = {busy_b, rd_en_b, cur_b, lpwm_b, rpwm_b, lfwd_b, rfwd_b, sd_b, qd_b};

    int errors = 0;
    int checks = 0;
    logic [3:0]  instrs [0:3];
    logic [11:0] exp_q [$];

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected outputs for RUN cycle j of an instruction, straight from the decode tables.
    function automatic logic [11:0] run_rec(input logic [3:0] ins, input int j, input int step);
        int   duty;
        logic p;
        logic [1:0] f;
        duty = 64 * (int'(ins[3:2]) + 1);
        p    = ((j % 256) < duty);
        case (ins[1:0])
            2'b00:   f = 2'b11;
            2'b01:   f = 2'b00;
            2'b10:   f = 2'b01;
            default: f = 2'b10;
        endcase
        return {1'b1, 1'b0, ins, p, p, f, (j == step - 1), 1'b0};
    endfunction

    // Timeline: per entry FETCH, LOAD, STEP RUN cycles, GAP cycles; then one queue_done IDLE cycle and a quiet one.
    task automatic build(input int n, input int step, input int gap);
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(12'hC00);
            exp_q.push_back(12'h800);
            for (int j = 0; j < step; j++) exp_q.push_back(run_rec(instrs[i], j, step));
            for (int g = 0; g < gap; g++) exp_q.push_back(12'h800);
        end
        exp_q.push_back(12'h001);
        exp_q.push_back(12'h000);
    endtask

    // stop_kind: 0 = run to completion, 1 = abort after record stop_at, 2 = async reset after record stop_at.
    task automatic run_check(input bit use_b, input int n, input int step, input int gap,
                             input bit push, input int stop_at, input int stop_kind, input string tag);
        build(n, step, gap);
        if (push) begin
            for (int i = 0; i < n; i++) begin
                mem[wr_ptr[4:0]] = instrs[i];
                wr_ptr = wr_ptr + 1;
            end
        end
        @(negedge clk);
        if (use_b) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        for (int idx = 0; idx < exp_q.size(); idx++) begin
            if (idx > 0) @(negedge clk);
            check(tag, use_b ? obs_b : obs_a, exp_q[idx]);
            if (idx == stop_at) begin
                if (stop_kind == 1) begin
                    abort = 1'b1;
                    @(negedge clk);
                    abort = 1'b0;
                    check("abort_idle", obs_a, 12'h000);
                    @(negedge clk);
                    check("abort_quiet", obs_a, 12'h000);
                end else begin
                    #2 reset_n = 1'b0;
                    #1 check("async_reset", obs_a, 12'h000);
                    @(negedge clk);
                    reset_n = 1'b1;
                    @(negedge clk);
                    check("post_reset", obs_a, 12'h000);
                end
                break;
            end
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("reset_a", obs_a, 12'h000);
        check("reset_b", obs_b, 12'h000);
        reset_n = 1'b1;
        @(negedge clk);

        instrs[0] = 4'b1100;
        run_check(1'b0, 1, STEP_A, GAP_A, 1'b1, -1, 0, "single_1100");

        instrs[0] = 4'b0010;
        run_check(1'b1, 1, STEP_B, GAP_B, 1'b1, -1, 0, "pwm_quarter");

        instrs[0] = 4'b0000;
        instrs[1] = 4'b0101;
        instrs[2] = 4'b1011;
        run_check(1'b0, 3, STEP_A, GAP_A, 1'b1, -1, 0, "three_dirs");

        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("empty_start", obs_a, 12'h000);
            @(negedge clk);
        end

        instrs[0] = 4'b0110;
        instrs[1] = 4'b1001;
        run_check(1'b0, 2, STEP_A, GAP_A, 1'b1, 5, 1, "abort_run");
        check("fifo_left", 12'(wr_ptr - rd_ptr), 12'd1);
        instrs[0] = 4'b1001;
        run_check(1'b0, 1, STEP_A, GAP_A, 1'b0, -1, 0, "after_abort");

        instrs[0] = 4'b0111;
        run_check(1'b0, 1, STEP_A, GAP_A, 1'b1, 2 + STEP_A, 2, "reset_gap");

        for (int r = 0; r < 6; r++) begin
            int n;
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) instrs[i] = 4'($urandom_range(0, 15));
            run_check(1'b0, n, STEP_A, GAP_A, 1'b1, -1, 0, "random_queue");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
